// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_REG_AW = 5;
  localparam int unsigned CNT_W          = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic [DEFAULT_REG_AW-1:0] rd_num;
    logic [DEFAULT_DATA_W-1:0] data;
  } wb_bundle_t;

endpackage

// File: rtl/mem_stage_wb_reg.sv
// MEM/WB pipeline register: loads the write-back bundle when enabled.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_en,
  input  wb_bundle_t bundle_d,
  output wb_bundle_t bundle_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundle_q <= '0;
    end else if (load_en) begin
      bundle_q <= bundle_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: performs the data-memory access over req/ack, stalls upstream, drives MEM/WB.
// Optional build macro MISALIGN_CHECK_EN rejects word-misaligned memory ops.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W         = DEFAULT_DATA_W,
  parameter int unsigned REG_AW         = DEFAULT_REG_AW,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              mem_write_en,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic [REG_AW-1:0] rd_num,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_rd_num,
  output logic [DATA_W-1:0] wb_data,
  output logic              bus_err,
  output logic              misalign_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dmem_req_q, dmem_req_d;
  logic                dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0]   dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic                rw_q, rw_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic                bus_err_q, bus_err_d;
  logic                mem_op_c, misalign_c, timeout_c, stall_c, wb_load_c;
  wb_bundle_t          wb_d, wb_q;

  assign mem_op_c  = in_valid & (mem_write_en | mem_to_reg);
  assign timeout_c = (state_q == ACCESS) & ~dmem_ack & (cnt_q == CNT_LAST);

`ifdef MISALIGN_CHECK_EN
  logic misalign_err_q;

  assign misalign_c = mem_op_c & (alu_result[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_err_q <= 1'b0;
    else        misalign_err_q <= misalign_c;
  end

  assign misalign_err = misalign_err_q;
`else
  assign misalign_c   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Next-state, request latching and write-back selection.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    rw_d         = rw_q;
    rd_d         = rd_q;
    bus_err_d    = 1'b0;
    stall_c      = 1'b0;
    // Only a retiring slot needs to reload; otherwise just clear a stale valid.
    wb_load_c    = wb_q.valid;
    wb_d           = wb_q;
    wb_d.valid     = 1'b0;
    wb_d.reg_write = 1'b0;

    case (state_q)
      IDLE: begin
        if (misalign_c) begin
          wb_load_c      = 1'b1;
          wb_d.valid     = 1'b1;
          wb_d.reg_write = 1'b0;
          wb_d.rd_num    = DEFAULT_REG_AW'(rd_num);
          wb_d.data      = DEFAULT_DATA_W'(alu_result);
        end else if (mem_op_c) begin
          stall_c      = 1'b1;
          state_d      = ACCESS;
          cnt_d        = '0;
          dmem_req_d   = 1'b1;
          dmem_we_d    = mem_write_en;
          dmem_addr_d  = alu_result;
          dmem_wdata_d = read_data_2;
          rw_d         = reg_write & ~mem_write_en;
          rd_d         = rd_num;
        end else if (in_valid) begin
          wb_load_c      = 1'b1;
          wb_d.valid     = 1'b1;
          wb_d.reg_write = reg_write;
          wb_d.rd_num    = DEFAULT_REG_AW'(rd_num);
          wb_d.data      = DEFAULT_DATA_W'(alu_result);
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d        = IDLE;
          dmem_req_d     = 1'b0;
          wb_load_c      = 1'b1;
          wb_d.valid     = 1'b1;
          wb_d.reg_write = rw_q;
          wb_d.rd_num    = DEFAULT_REG_AW'(rd_q);
          wb_d.data      = dmem_we_q ? DEFAULT_DATA_W'(dmem_addr_q)
                                     : DEFAULT_DATA_W'(dmem_rdata);
        end else if (timeout_c) begin
          state_d        = IDLE;
          dmem_req_d     = 1'b0;
          bus_err_d      = 1'b1;
          wb_load_c      = 1'b1;
          wb_d.valid     = 1'b1;
          wb_d.reg_write = 1'b0;
          wb_d.rd_num    = DEFAULT_REG_AW'(rd_q);
          wb_d.data      = DEFAULT_DATA_W'(dmem_addr_q);
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      rw_q         <= 1'b0;
      rd_q         <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      rw_q         <= rw_d;
      rd_q         <= rd_d;
      bus_err_q    <= bus_err_d;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (wb_load_c),
    .bundle_d (wb_d),
    .bundle_q (wb_q)
  );

  // Stall must also fall the instant reset asserts, whatever the inputs show.
  assign stall        = rst_n & stall_c;
  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign bus_err      = bus_err_q;
  assign wb_valid     = wb_q.valid;
  assign wb_reg_write = wb_q.reg_write;
  assign wb_rd_num    = REG_AW'(wb_q.rd_num);
  assign wb_data      = DATA_W'(wb_q.data);

endmodule
